// File: rtl/v_mac_dot_sequencer.sv
// rtl/v_mac_dot_sequencer.sv - sequencer owning a register/multiply/accumulate pipeline for unsigned dot products
module v_mac_dot_sequencer #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  output logic                 busy,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*WIDTH-1:0]   res,
  output logic                 res_ovf,
  output logic                 res_valid,
  input  logic                 res_ready
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         drain_q, drain_d;
  logic [WIDTH-1:0]   ra_q, ra_d, rb_q, rb_d;
  logic [2*WIDTH-1:0] mult_q, mult_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               v1_q, v1_d, v2_q, v2_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               in_ready_q, in_ready_d;
  logic               res_valid_q, res_valid_d;
  logic               beat;
  logic [2*WIDTH:0]   sum;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    drain_d  = drain_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    v1_d     = 1'b0;
    beat     = in_valid & in_ready_q;
    sum      = {1'b0, acc_q} + {1'b0, mult_q};
    mult_d   = {{WIDTH{1'b0}}, ra_q} * {{WIDTH{1'b0}}, rb_q};
    v2_d     = v1_q;

    // The multiply/accumulate stages run every cycle regardless of FSM state.
    if (v2_q) begin
      acc_d = sum[2*WIDTH-1:0];
      ovf_d = ovf_q | sum[2*WIDTH];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          drain_d = '0;
          state_d = (len == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (beat) begin
          ra_d  = a_in;
          rb_d  = b_in;
          v1_d  = 1'b1;
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end
        end
      end
      S_DRAIN: begin
        // Hold until the final product has passed multiply and accumulate.
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'd2) state_d = S_DONE;
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    in_ready_d  = (state_d == S_LOAD);
    res_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      drain_q     <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      mult_q      <= '0;
      acc_q       <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      mult_q      <= mult_d;
      acc_q       <= acc_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign busy      = busy_q;
  assign in_ready  = in_ready_q;
  assign res       = acc_q;
  assign res_ovf   = ovf_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_v_mac_dot_sequencer.sv
// tb/tb_v_mac_dot_sequencer.sv - scoreboard bench for v_mac_dot_sequencer
module tb_v_mac_dot_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic [7:0]  a_in = '0;
  logic [7:0]  b_in = '0;
  logic        in_valid = 1'b0;
  logic        res_ready = 1'b1;
  logic        busy, in_ready, res_ovf, res_valid;
  logic [15:0] res;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   av[8];
  int   bv[8];

  v_mac_dot_sequencer #(.WIDTH(8), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .a_in(a_in), .b_in(b_in), .in_valid(in_valid), .in_ready(in_ready),
    .res(res), .res_ovf(res_ovf), .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int n);
    longint s;
    exp_t   e;
    s = 0;
    for (int i = 0; i < n; i++) s += longint'(av[i]) * longint'(bv[i]);
    e.res = 16'(s % 65536);
    e.ovf = (s > 65535);
    sb.push_back(e);
  endtask

  task automatic start_cmd(input int n);
    @(negedge clk);
    len   = 8'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_pairs(input int n, input bit gaps);
    int k;
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      a_in     = 8'(av[i]);
      b_in     = 8'(bv[i]);
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 20) begin
        @(negedge clk);
        k++;
      end
      check_val("beat_ready", 32'(in_ready), 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int exp_lat);
    int   lat;
    exp_t e;
    lat = 0;
    while (!res_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check_val("res_valid_seen", 32'(res_valid), 1);
    if (exp_lat >= 0) check_val("latency", 32'(lat), 32'(exp_lat));
    if (sb.size() == 0) begin
      check_val("sb_underflow", 32'(sb.size()), 1);
    end else begin
      e = sb.pop_front();
      check_val("res", 32'(res), 32'(e.res));
      check_val("res_ovf", 32'(res_ovf), 32'(e.ovf));
    end
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    check_val({tag, "_res_valid"}, 32'(res_valid), 0);
    check_val({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_busy"}, 32'(busy), 0);
    check_val({tag, "_in_ready"}, 32'(in_ready), 0);
    check_val({tag, "_res_valid"}, 32'(res_valid), 0);
    check_val({tag, "_res_ovf"}, 32'(res_ovf), 0);
    check_val({tag, "_res"}, 32'(res), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b1;

    // T1: back-to-back beats
    av[0] = 2; bv[0] = 3; av[1] = 4; bv[1] = 5; av[2] = 6; bv[2] = 7;
    push_exp(3);
    start_cmd(3);
    check_val("t1_in_ready_load", 32'(in_ready), 1);
    send_pairs(3, 1'b0);
    check_val("t1_in_ready_drop", 32'(in_ready), 0);
    wait_result(3);
    expect_idle("t1");

    // T2: gaps between beats
    push_exp(3);
    start_cmd(3);
    send_pairs(3, 1'b1);
    check_val("t2_in_ready_drop", 32'(in_ready), 0);
    wait_result(3);
    expect_idle("t2");

    // T3: wraparound with sticky overflow
    av[0] = 255; bv[0] = 255; av[1] = 255; bv[1] = 255;
    push_exp(2);
    start_cmd(2);
    send_pairs(2, 1'b0);
    wait_result(3);
    expect_idle("t3");

    // T4: zero length, then a single beat
    push_exp(0);
    start_cmd(0);
    check_val("t4_no_in_ready", 32'(in_ready), 0);
    check_val("t4_busy", 32'(busy), 1);
    wait_result(0);
    expect_idle("t4a");
    av[0] = 9; bv[0] = 9;
    push_exp(1);
    start_cmd(1);
    send_pairs(1, 1'b0);
    wait_result(3);
    expect_idle("t4b");

    // T5: backpressure on result with start pulsed in DONE
    av[0] = 1; bv[0] = 2; av[1] = 3; bv[1] = 4;
    res_ready = 1'b0;
    push_exp(2);
    start_cmd(2);
    send_pairs(2, 1'b0);
    wait_result(3);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      len   = 8'd5;
      @(negedge clk);
      check_val("t5_hold_res", 32'(res), 14);
      check_val("t5_hold_valid", 32'(res_valid), 1);
    end
    start     = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("t5_idle_busy", 32'(busy), 0);
    check_val("t5_idle_valid", 32'(res_valid), 0);
    check_val("t5_idle_res", 32'(res), 14);
    av[0] = 5; bv[0] = 6;
    push_exp(1);
    start_cmd(1);
    send_pairs(1, 1'b0);
    wait_result(3);
    expect_idle("t5b");

    // T6: reset mid-load discards the command
    av[0] = 1; bv[0] = 1; av[1] = 2; bv[1] = 2;
    start_cmd(4);
    send_pairs(2, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_zero_outputs("t6_reset");
    av[0] = 3; bv[0] = 4;
    push_exp(1);
    start_cmd(1);
    send_pairs(1, 1'b0);
    wait_result(3);
    expect_idle("t6");

    check_val("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
